mnet_layer_sequencer: RTL and testbench
=======================================

// Module: mnet_layer_sequencer
// PURPOSE
//  Time-multiplexed controller for the mini-MobileNet inference pipeline.
//  Accepts one image per in_valid/in_ready handshake, then steps a single shared compute engine
//  through four stages: CONV (3 ch), DW (3 ch), PW (8 ch), FC (10 outputs).
//  For each channel it issues a start pulse with stage, channel and weight-ROM base address,
//  waits for the engine's done, and finally presents out_valid/out_ready to the classifier sink.
// PARAMETERS
//  ADDR_W          9    weight-ROM address width
//  CH_W            4    channel-index width (max 10 channels)
//  TIMEOUT_CYCLES  64   max cycles waiting for eng_done before error
// PORTS
//  clk          in   1       clock, rising edge
//  rst_n        in   1       asynchronous active-low reset
//  in_valid     in   1       new image available
//  in_ready     out  1       controller idle, can accept image
//  eng_start    out  1       one-cycle engine start pulse
//  eng_stage    out  2       stage_e: 0 CONV, 1 DW, 2 PW, 3 FC
//  eng_chan     out  CH_W    channel index within stage
//  eng_wt_addr  out  ADDR_W  weight+bias base address for this channel
//  eng_done     in   1       engine finished current channel
//  out_valid    out  1       inference complete, result valid
//  out_ready    in   1       sink accepts result
//  busy         out  1       inference in progress (not IDLE, not ERR)
//  err          out  1       sticky watchdog timeout flag
//  err_clr      in   1       clears err, returns to IDLE
// BEHAVIOUR
//  Reset: state IDLE; in_ready=1; eng_start, out_valid, busy, err = 0; stage, chan, addr = 0.
//  FSM states: IDLE, ISSUE, WAIT, DONE, ERR.
//  IDLE : in_ready=1. in_valid -> ISSUE with stage=CONV, chan=0.
//  ISSUE: eng_start=1 for exactly one cycle; stage/chan/addr are stable from ISSUE until leaving WAIT. -> WAIT.
//  WAIT : eng_done=1 -> advance chan; at last chan of stage, chan=0 and stage++.
//         After FC chan 9 -> DONE, else -> ISSUE.
//  Watchdog: counter cleared in ISSUE, increments in WAIT.
//         At TIMEOUT_CYCLES with no done -> ERR. eng_done in the same cycle wins.
//  DONE : out_valid=1, held until out_ready; then -> IDLE. out_valid never drops without out_ready.
//  ERR  : err=1, busy=0, in_ready=0. err_clr -> IDLE and err=0. in_valid is ignored.
//  eng_done outside WAIT is ignored (no state change, no count).
//  eng_wt_addr = STAGE_BASE[stage] + chan*STAGE_STRIDE[stage], computed ADDR_W wide, no wrap.
//    CONV 0/10, DW 30/10, PW 60/4, FC 92/33; max address 389.
//  Latency, engine done L cycles after start:
//    first eng_start is 1 cycle after accept; each next start is 1 cycle after done;
//    out_valid is 1 cycle after last done; total 24*(L+1)+1 cycles.
//  Reset mid-operation aborts immediately. No partial state persists; next image restarts at CONV ch0.
// CONFIGURATION
//  MNET_PERF_CNT_EN defined: adds output perf_cycles[15:0].
//    Counts cycles from accept (exclusive) to out_valid rise (inclusive); latched at DONE entry.
//    Holds until next accept; reset 0; saturates at 16'hFFFF.
//  Undefined: port and counter are absent; behaviour otherwise identical.
// STRUCTURE
//  Package mnet_pkg:
//    stage_e enum; STAGE_CHANNELS {3,3,8,10}; STAGE_BASE / STAGE_STRIDE arrays;
//    LAST_STAGE constant; shared with the engine and the weight-ROM builder.
//  Sub-module mnet_watchdog: clear/enable inputs, expired output parameterised by TIMEOUT_CYCLES.
//  FSM, channel counter and address generation stay in this module.
// TESTING
//  1. in_valid 1 cycle, engine done L=2 -> 24 start pulses; addrs 0,10,20,30,...,60,...,88,92,...,389;
//     out_valid at cycle 73.
//  2. out_ready low 5 cycles in DONE -> out_valid stays 1, in_ready 0, second in_valid not accepted
//     until the handshake.
//  3. Withhold eng_done at PW ch2 -> err=1 after 64 WAIT cycles, busy=0.
//     err_clr -> IDLE; next image completes normally.
//  4. eng_done pulses in IDLE and in DONE -> no start pulse, state unchanged.
//  5. rst_n low during FC ch4 WAIT -> all outputs at reset values asynchronously;
//     next image first start has addr 0, stage CONV.
//  6. MNET_PERF_CNT_EN, L=2 -> perf_cycles=73. L=5 -> 145. Value held after out handshake.

Source files
------------

// File: rtl/mnet_pkg.sv
// mnet_pkg: shared stage/state types and per-stage channel count and weight-ROM layout tables
package mnet_pkg;
  typedef enum logic [1:0] {CONV, DW, PW, FC} stage_e;
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, DONE, ERR} state_e;
  localparam stage_e LAST_STAGE = FC;
  localparam int STAGE_CHANNELS [4] = '{3, 3, 8, 10};
  localparam int STAGE_BASE [4] = '{0, 30, 60, 92};
  localparam int STAGE_STRIDE [4] = '{10, 10, 4, 33};
  function automatic int stage_addr(stage_e s, int c);
    return STAGE_BASE[s] + c * STAGE_STRIDE[s];
  endfunction
endpackage

// File: rtl/mnet_layer_sequencer_if.sv
// mnet_layer_sequencer_if: image, engine and result handshakes of the layer sequencer
interface mnet_layer_sequencer_if import mnet_pkg::*; #(
  parameter int ADDR_W = 9,
  parameter int CH_W = 4
);
  logic in_valid, in_ready, eng_start, eng_done, out_valid, out_ready;
  stage_e eng_stage;
  logic [CH_W-1:0] eng_chan;
  logic [ADDR_W-1:0] eng_wt_addr;
  modport master (
    input in_valid, eng_done, out_ready,
    output in_ready, eng_start, eng_stage, eng_chan, eng_wt_addr, out_valid
  );
  modport slave (
    output in_valid, eng_done, out_ready,
    input in_ready, eng_start, eng_stage, eng_chan, eng_wt_addr, out_valid
  );
endinterface

// File: rtl/mnet_watchdog.sv
// mnet_watchdog: flags a wait that reaches TIMEOUT_CYCLES enabled cycles since the last clear
module mnet_watchdog #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);
  localparam int W = $clog2(TIMEOUT_CYCLES + 1);
  logic [W-1:0] cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else cnt <= clr ? '0 : en ? cnt + W'(1) : cnt;
  assign expired = en && cnt == W'(TIMEOUT_CYCLES - 1);
endmodule

// File: rtl/mnet_layer_sequencer.sv
// mnet_layer_sequencer: steps the shared engine through CONV/DW/PW/FC channels; MNET_PERF_CNT_EN adds perf_cycles
module mnet_layer_sequencer import mnet_pkg::*; #(
  parameter int ADDR_W = 9,
  parameter int CH_W = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic clk,
  input  logic rst_n,
  mnet_layer_sequencer_if.master bus,
  output logic busy,
  output logic err,
  input  logic err_clr
`ifdef MNET_PERF_CNT_EN
  ,
  output logic [15:0] perf_cycles
`endif
);
  state_e state, state_d;
  stage_e stage, stage_d;
  logic [CH_W-1:0] chan, chan_d;
  logic expired, last_chan;
  assign last_chan = int'(chan) == STAGE_CHANNELS[stage] - 1;
  assign bus.in_ready = state == IDLE;
  assign bus.eng_start = state == ISSUE;
  assign bus.out_valid = state == DONE;
  assign err = state == ERR;
  assign busy = state != IDLE && state != ERR;
  assign bus.eng_stage = stage;
  assign bus.eng_chan = chan;
  assign bus.eng_wt_addr = ADDR_W'(stage_addr(stage, int'(chan)));
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      stage <= CONV;
      chan <= '0;
    end else begin
      state <= state_d;
      stage <= stage_d;
      chan <= chan_d;
    end
  always_comb begin
    state_d = state;
    stage_d = stage;
    chan_d = chan;
    case (state)
      IDLE: if (bus.in_valid) begin
        state_d = ISSUE;
        stage_d = CONV;
        chan_d = '0;
      end
      ISSUE: state_d = WAIT;
      WAIT: if (bus.eng_done) begin
        state_d = last_chan && stage == LAST_STAGE ? DONE : ISSUE;
        stage_d = !last_chan ? stage : stage == LAST_STAGE ? CONV : stage_e'(stage + 2'd1);
        chan_d = last_chan ? '0 : chan + CH_W'(1);
      end else if (expired) state_d = ERR;
      DONE: if (bus.out_ready) state_d = IDLE;
      ERR: if (err_clr) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  mnet_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_wd (
    .clk(clk),
    .rst_n(rst_n),
    .clr(state == ISSUE),
    .en(state == WAIT),
    .expired(expired)
  );
`ifdef MNET_PERF_CNT_EN
  logic [15:0] perf_run;
  logic [16:0] run_inc, run_fin;
  assign run_inc = {1'b0, perf_run} + 17'd1;
  assign run_fin = {1'b0, perf_run} + 17'd2;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      perf_run <= '0;
      perf_cycles <= '0;
    end else if (state == IDLE && bus.in_valid) begin
      perf_run <= '0;
      perf_cycles <= '0;
    end else begin
      if (busy) perf_run <= run_inc[16] ? '1 : run_inc[15:0];
      if (state == WAIT && state_d == DONE) perf_cycles <= run_fin[16] ? '1 : run_fin[15:0];
    end
`endif
endmodule

// File: tb/tb_mnet_layer_sequencer.sv
// tb_mnet_layer_sequencer: scoreboard bench with a randomized engine model and spec-level reference
module tb_mnet_layer_sequencer;
  logic clk = 0, rst_n = 0, busy, err, err_clr = 0;
`ifdef MNET_PERF_CNT_EN
  logic [15:0] perf_cycles;
`endif
  mnet_layer_sequencer_if bus ();
  mnet_layer_sequencer dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus),
    .busy(busy),
    .err(err),
    .err_clr(err_clr)
`ifdef MNET_PERF_CNT_EN
    ,
    .perf_cycles(perf_cycles)
`endif
  );
  typedef struct {int s; int c; int a;} start_t;
  start_t exp_q[$];
  int lat_q[$], acc_q[$];
  int checks = 0, errors = 0, cyc = 0;
  int lat = 2, withhold = -1, nstarts = 0, last_start_cyc = 0, timer = 0;
  bit inject = 0;
  logic pv = 0, pr = 0;
  int ch_n[4] = '{3, 3, 8, 10};
  int base[4] = '{0, 30, 60, 92};
  int stride[4] = '{10, 10, 4, 33};
  initial forever #5 clk = ~clk;
  initial forever begin
    @(posedge clk);
    cyc++;
  end
  task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", n, act, exp);
    end
  endtask
  initial forever begin
    @(negedge clk);
    bus.eng_done = inject;
    if (!rst_n) timer = 0;
    else if (timer > 0) begin
      timer--;
      if (timer == 0) bus.eng_done = 1;
    end
    if (bus.eng_start) begin
      nstarts++;
      last_start_cyc = cyc;
      timer = (nstarts - 1 == withhold) ? 0 : lat;
    end
  end
  initial forever begin
    start_t e;
    int l, a;
    @(negedge clk);
    #1;
    if (bus.eng_start) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_start: got stage %0d chan %0d, want none", bus.eng_stage, bus.eng_chan);
      end else begin
        e = exp_q.pop_front();
        chk("start_stage", bus.eng_stage, e.s);
        chk("start_chan", bus.eng_chan, e.c);
        chk("start_addr", bus.eng_wt_addr, e.a);
      end
    end
    if (bus.out_valid && !pv) begin
      if (lat_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out_valid: got 1, want 0");
      end else begin
        l = lat_q.pop_front();
        a = acc_q.pop_front();
        chk("latency", cyc - a, l);
        chk("starts_left", exp_q.size(), 0);
`ifdef MNET_PERF_CNT_EN
        chk("perf_cycles", perf_cycles, l);
`endif
      end
    end
    if (pv && !pr) chk("out_valid_hold", bus.out_valid, 1);
    pv = bus.out_valid;
    pr = bus.out_ready;
  end
  task automatic send_image(int l);
    int n = 0;
    bus.in_valid = 1;
    while (!bus.in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got in_ready 0, want 1");
      bus.in_valid = 0;
      return;
    end
    lat = l;
    nstarts = 0;
    for (int s = 0; s < 4; s++)
      for (int c = 0; c < ch_n[s]; c++) exp_q.push_back('{s, c, base[s] + c * stride[s]});
    lat_q.push_back(24 * (l + 1) + 1);
    acc_q.push_back(cyc);
    @(negedge clk);
    bus.in_valid = 0;
  endtask
  task automatic wait_out(int hold, bit pend, bit inj);
    int n = 0;
    while (!bus.out_valid && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (!bus.out_valid) begin
      checks++;
      errors++;
      $display("FAIL out_valid_timeout: got 0, want 1");
      return;
    end
    bus.in_valid = pend;
    bus.out_ready = 0;
    inject = inj;
    repeat (hold) begin
      @(negedge clk);
      chk("done_in_ready", bus.in_ready, 0);
      chk("done_start", bus.eng_start, 0);
      chk("done_busy", busy, 1);
    end
    inject = 0;
    bus.out_ready = 1;
    @(negedge clk);
    bus.out_ready = 0;
    chk("hs_in_ready", bus.in_ready, 1);
    chk("hs_out_valid", bus.out_valid, 0);
`ifdef MNET_PERF_CNT_EN
    chk("perf_hold", perf_cycles, 24 * (lat + 1) + 1);
`endif
  endtask
  initial begin
    int n;
    bus.in_valid = 0;
    bus.out_ready = 0;
    bus.eng_done = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_start", bus.eng_start, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    chk("rst_addr", bus.eng_wt_addr, 0);
`ifdef MNET_PERF_CNT_EN
    chk("rst_perf", perf_cycles, 0);
`endif
    inject = 1;
    repeat (3) begin
      @(negedge clk);
      chk("idle_done_in_ready", bus.in_ready, 1);
      chk("idle_done_start", bus.eng_start, 0);
    end
    inject = 0;
    @(negedge clk);
    send_image(2);
    wait_out(0, 0, 0);
    send_image(2);
    wait_out(5, 1, 1);
    send_image(5);
    wait_out(1, 0, 0);
    for (int i = 0; i < 4; i++) begin
      send_image($urandom_range(1, 6));
      wait_out($urandom_range(0, 3), 0, 0);
    end
    send_image(64);
    wait_out(0, 0, 0);
    withhold = 8;
    send_image(2);
    n = 0;
    while (!err && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("err_set", err, 1);
    chk("err_delay", cyc - last_start_cyc, 65);
    chk("err_busy", busy, 0);
    chk("err_in_ready", bus.in_ready, 0);
    exp_q.delete();
    lat_q.delete();
    acc_q.delete();
    withhold = -1;
    bus.in_valid = 1;
    repeat (3) begin
      @(negedge clk);
      chk("err_ignore_in", bus.in_ready, 0);
      chk("err_sticky", err, 1);
    end
    bus.in_valid = 0;
    err_clr = 1;
    @(negedge clk);
    err_clr = 0;
    chk("clr_err", err, 0);
    chk("clr_in_ready", bus.in_ready, 1);
    send_image(3);
    wait_out(0, 0, 0);
    send_image(3);
    n = 0;
    while (nstarts < 19 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    chk("pre_rst_stage", bus.eng_stage, 3);
    chk("pre_rst_chan", bus.eng_chan, 4);
    chk("pre_rst_busy", busy, 1);
    #2 rst_n = 0;
    #1;
    chk("arst_in_ready", bus.in_ready, 1);
    chk("arst_busy", busy, 0);
    chk("arst_stage", bus.eng_stage, 0);
    chk("arst_chan", bus.eng_chan, 0);
    chk("arst_addr", bus.eng_wt_addr, 0);
    exp_q.delete();
    lat_q.delete();
    acc_q.delete();
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    send_image(2);
    wait_out(2, 0, 1);
    repeat (3) @(negedge clk);
    chk("queues_empty", exp_q.size() + lat_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
  initial begin
    #1000000;
    $display("FAIL global_timeout: got no finish, want finish");
    $fatal(1, "timeout");
  end
endmodule
